// File: rtl/lg_pkg.sv
// Shared constants, filter action encoding and popcount helper for the NOR bank.
// Optional edge-pulse outputs are enabled with the LG_NOR_EDGE_PULSE_EN macro.
package lg_pkg;

   localparam int LG_CH_DEF     = 4;
   localparam int LG_NIN_DEF    = 5;
   localparam int LG_FILT_W_DEF = 4;
   localparam int LG_TOG_W_DEF  = 16;

   // Popcount operates on a fixed-width vector; banks wider than this are not supported.
   localparam int LG_POP_IN_W  = 64;
   localparam int LG_POP_OUT_W = 7;

   typedef enum logic [1:0] {
      FILT_IDLE  = 2'd0,
      FILT_COUNT = 2'd1,
      FILT_LOAD  = 2'd2
   } filt_act_e;

   function automatic logic [LG_POP_OUT_W-1:0] lg_popcount(input logic [LG_POP_IN_W-1:0] v);
      logic [LG_POP_OUT_W-1:0] s;
      s = '0;
      for (int i = 0; i < LG_POP_IN_W; i++) begin
         s = s + {{(LG_POP_OUT_W-1){1'b0}}, v[i]};
      end
      return s;
   endfunction

endpackage

// File: rtl/lg_nor_filt_ch.sv
// One NOR channel: masked/strobed raw term, sample register and deglitch filter.
// Edge pulses exist only when LG_NOR_EDGE_PULSE_EN is defined.
module lg_nor_filt_ch
   import lg_pkg::*;
#(
   parameter int NIN    = LG_NIN_DEF,
   parameter int FILT_W = LG_FILT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NIN-1:0]    a_i,
   input  logic [NIN-1:0]    in_mask_i,
   input  logic              g_i,
   input  logic [FILT_W-1:0] filt_len_i,
   output logic              y_o,
   output logic              toggle_o
`ifdef LG_NOR_EDGE_PULSE_EN
   ,
   output logic              y_rise_o,
   output logic              y_fall_o
`endif
);

   localparam logic [FILT_W-1:0] CNT_ONE = {{(FILT_W-1){1'b0}}, 1'b1};

   logic              raw;
   logic              samp_q, samp_d;
   logic              y_q, y_d;
   logic [FILT_W-1:0] cnt_q, cnt_d;
   filt_act_e         act;

   // Strobe low or an empty mask both leave the NOR output inactive (high).
   assign raw = ~(g_i & (|(a_i & in_mask_i)));

   always_comb begin
      act = FILT_IDLE;
      if (samp_q != y_q) begin
         act = (cnt_q >= filt_len_i) ? FILT_LOAD : FILT_COUNT;
      end
   end

   // cnt never exceeds filt_len when it increments, so it cannot wrap.
   always_comb begin
      samp_d = raw;
      y_d    = y_q;
      cnt_d  = cnt_q;
      case (act)
         FILT_IDLE:  cnt_d = '0;
         FILT_COUNT: cnt_d = cnt_q + CNT_ONE;
         FILT_LOAD: begin
            y_d   = samp_q;
            cnt_d = '0;
         end
         default:    cnt_d = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         samp_q <= 1'b1;
         y_q    <= 1'b1;
         cnt_q  <= '0;
      end else begin
         samp_q <= samp_d;
         y_q    <= y_d;
         cnt_q  <= cnt_d;
      end
   end

   assign y_o      = y_q;
   assign toggle_o = (act == FILT_LOAD);

`ifdef LG_NOR_EDGE_PULSE_EN
   logic rise_q, fall_q;

   // Pulses are registered at the same edge that loads y, so they align with the new value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= (act == FILT_LOAD) &  samp_q;
         fall_q <= (act == FILT_LOAD) & ~samp_q;
      end
   end

   assign y_rise_o = rise_q;
   assign y_fall_o = fall_q;
`endif

endmodule

// File: rtl/lg_nor_bank_filt.sv
// Bank of CH filtered NOR channels with a saturating transition counter.
// Define LG_NOR_EDGE_PULSE_EN to add per-channel y_rise / y_fall pulse outputs.
module lg_nor_bank_filt
   import lg_pkg::*;
#(
   parameter int CH     = LG_CH_DEF,
   parameter int NIN    = LG_NIN_DEF,
   parameter int FILT_W = LG_FILT_W_DEF,
   parameter int TOG_W  = LG_TOG_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CH*NIN-1:0] a,
   input  logic [CH*NIN-1:0] in_mask,
   input  logic [CH-1:0]     g,
   input  logic [FILT_W-1:0] filt_len,
   input  logic              tog_clr,
   output logic [CH-1:0]     y,
   output logic [TOG_W-1:0]  tog_cnt
`ifdef LG_NOR_EDGE_PULSE_EN
   ,
   output logic [CH-1:0]     y_rise,
   output logic [CH-1:0]     y_fall
`endif
);

   localparam int SUM_W = TOG_W + LG_POP_OUT_W;
   localparam logic [SUM_W-1:0] TOG_MAX = {{LG_POP_OUT_W{1'b0}}, {TOG_W{1'b1}}};

   logic [CH-1:0]           toggle;
   logic [LG_POP_OUT_W-1:0] pop;
   logic [SUM_W-1:0]        sum;
   logic [TOG_W-1:0]        tog_cnt_q, tog_cnt_d;

   for (genvar c = 0; c < CH; c++) begin : g_ch
      lg_nor_filt_ch #(
         .NIN    (NIN),
         .FILT_W (FILT_W)
      ) u_ch (
         .clk        (clk),
         .rst        (rst),
         .a_i        (a[c*NIN +: NIN]),
         .in_mask_i  (in_mask[c*NIN +: NIN]),
         .g_i        (g[c]),
         .filt_len_i (filt_len),
         .y_o        (y[c]),
         .toggle_o   (toggle[c])
`ifdef LG_NOR_EDGE_PULSE_EN
         ,
         .y_rise_o   (y_rise[c]),
         .y_fall_o   (y_fall[c])
`endif
      );
   end

   assign pop = lg_popcount(LG_POP_IN_W'(toggle));
   assign sum = SUM_W'(tog_cnt_q) + SUM_W'(pop);

   // Clear beats any coincident toggles; otherwise add and clamp at all-ones.
   always_comb begin
      tog_cnt_d = tog_cnt_q;
      if (tog_clr) begin
         tog_cnt_d = '0;
      end else if (sum > TOG_MAX) begin
         tog_cnt_d = '1;
      end else begin
         tog_cnt_d = sum[TOG_W-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tog_cnt_q <= '0;
      end else begin
         tog_cnt_q <= tog_cnt_d;
      end
   end

   assign tog_cnt = tog_cnt_q;

endmodule
